// File: rtl/vc_arbiter_if.sv
// ---------------------------------------------------------------------------
// vc_arbiter_if
//   Bundles every non-clock/reset signal of the VC arbiter: the arbitration
//   enable, both virtual-channel source FIFO ports, both destination FIFO
//   ports, and the status outputs.
//
//   modport master : the arbiter side (drives pops, pushes, status)
//   modport slave  : the environment side (drives FIFO flags/data, init)
//
//   Signals
//     init                 arbitration enable
//     vcN_empty/head/data  source FIFO empty flag, head word, read data
//     vcN_pop              source read strobe
//     dN_almost_full       destination backpressure
//     dN_push/data         destination write strobe and data
//     active_vc            one-hot {vc1, vc0} of the word in flight
//     vcN_count            completed transfers per VC (wraps)
// ---------------------------------------------------------------------------
interface vc_arbiter_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  init;
    logic                  vc0_empty;
    logic                  vc1_empty;
    logic [DATA_WIDTH-1:0] vc0_head;
    logic [DATA_WIDTH-1:0] vc1_head;
    logic [DATA_WIDTH-1:0] vc0_data;
    logic [DATA_WIDTH-1:0] vc1_data;
    logic                  vc0_pop;
    logic                  vc1_pop;
    logic                  d0_almost_full;
    logic                  d1_almost_full;
    logic                  d0_push;
    logic                  d1_push;
    logic [DATA_WIDTH-1:0] d0_data;
    logic [DATA_WIDTH-1:0] d1_data;
    logic [1:0]            active_vc;
    logic [7:0]            vc0_count;
    logic [7:0]            vc1_count;

    modport master (
        input  init, vc0_empty, vc1_empty, vc0_head, vc1_head,
               vc0_data, vc1_data, d0_almost_full, d1_almost_full,
        output vc0_pop, vc1_pop, d0_push, d1_push, d0_data, d1_data,
               active_vc, vc0_count, vc1_count
    );

    modport slave (
        output init, vc0_empty, vc1_empty, vc0_head, vc1_head,
               vc0_data, vc1_data, d0_almost_full, d1_almost_full,
        input  vc0_pop, vc1_pop, d0_push, d1_push, d0_data, d1_data,
               active_vc, vc0_count, vc1_count
    );
endinterface

// File: rtl/vc_arbiter.sv
// ---------------------------------------------------------------------------
// vc_arbiter
//   Moves words from two virtual-channel FIFOs (VC0, VC1) into two
//   destination FIFOs (D0, D1). In ARB one eligible source is granted and
//   popped; in the following XFER cycle the popped word is pushed into the
//   destination chosen by bit DEST_BIT of the head word seen at grant time.
//   VC0 has priority. Throughput is at most one word every two cycles.
//
//   Optional feature (macro VC_ARB_ANTISTARVE_EN): a saturating streak
//   counter of VC0 grants taken while VC1 was eligible; once it reaches
//   MAX_BURST, an eligible VC1 is granted ahead of VC0.
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous active-high reset; also suppresses pops/pushes
//            combinationally so an in-flight word is dropped
//     bus    vc_arbiter_if.master (FIFO ports, init, status outputs)
// ---------------------------------------------------------------------------
module vc_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic          clk,
    input  logic          reset,
    vc_arbiter_if.master  bus
);

    typedef enum logic {ARB = 1'b0, XFER = 1'b1} state_t;

    state_t r_state;
    state_t w_state_next;

    // Index 0 = VC0 / D0, index 1 = VC1 / D1
    logic [1:0]            w_empty;
    logic [1:0]            w_af;
    logic [1:0]            w_dsel;      // destination requested by each head word
    logic [1:0]            w_elig;
    logic [1:0]            w_grant;     // one-hot, doubles as the pop strobes
    logic [1:0]            w_push;
    logic [DATA_WIDTH-1:0] w_src_data;
    logic [DATA_WIDTH-1:0] w_dout [2];

    logic                  r_vc;        // latched source: 0 = VC0, 1 = VC1
    logic                  r_dest;      // latched destination: 0 = D0, 1 = D1
    logic [7:0]            r_vc0_count;
    logic [7:0]            r_vc1_count;

    assign w_empty = {bus.vc1_empty, bus.vc0_empty};
    assign w_af    = {bus.d1_almost_full, bus.d0_almost_full};
    assign w_dsel  = {bus.vc1_head[DEST_BIT], bus.vc0_head[DEST_BIT]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_elig
            // A source only competes if its own target has room.
            assign w_elig[gi] = !w_empty[gi] && !w_af[w_dsel[gi]];
        end
    endgenerate

`ifdef VC_ARB_ANTISTARVE_EN
    localparam int STREAK_W = ($clog2(MAX_BURST + 1) > 3) ? $clog2(MAX_BURST + 1) : 3;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_BURST);

    logic [STREAK_W-1:0] r_streak;
    logic                w_force_vc1;

    assign w_force_vc1 = (r_streak == STREAK_MAX) && w_elig[1];

    // Streak saturates at MAX_BURST; at that value the next eligible VC1
    // request wins and clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak <= '0;
        end else if (w_grant[1]) begin
            r_streak <= '0;
        end else if (w_grant[0] && w_elig[1] && (r_streak != STREAK_MAX)) begin
            r_streak <= r_streak + 1'b1;
        end
    end
`endif

    // Arbitration: only in ARB, with init high and not in reset.
    always_comb begin
        w_grant = 2'b00;
        if ((r_state == ARB) && bus.init && !reset) begin
`ifdef VC_ARB_ANTISTARVE_EN
            if (w_elig[1] && (!w_elig[0] || w_force_vc1)) begin
                w_grant = 2'b10;
            end else if (w_elig[0]) begin
                w_grant = 2'b01;
            end
`else
            if (w_elig[0]) begin
                w_grant = 2'b01;
            end else if (w_elig[1]) begin
                w_grant = 2'b10;
            end
`endif
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB:     w_state_next = (w_grant != 2'b00) ? XFER : ARB;
            XFER:    w_state_next = ARB;
            default: w_state_next = ARB;
        endcase
    end

    // Grant latch and transfer counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vc        <= 1'b0;
            r_dest      <= 1'b0;
            r_vc0_count <= 8'd0;
            r_vc1_count <= 8'd0;
        end else begin
            if (w_grant != 2'b00) begin
                r_vc   <= w_grant[1];
                r_dest <= w_grant[1] ? w_dsel[1] : w_dsel[0];
            end
            if (r_state == XFER) begin
                if (r_vc) begin
                    r_vc1_count <= r_vc1_count + 8'd1;
                end else begin
                    r_vc0_count <= r_vc0_count + 8'd1;
                end
            end
        end
    end

    // Output logic. The word leaves the source FIFO in ARB, so XFER pushes
    // unconditionally (backpressure is not re-sampled); only reset drops it.
    assign w_src_data = r_vc ? bus.vc1_data : bus.vc0_data;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_dest
            assign w_push[gi] = (r_state == XFER) && !reset && (r_dest == 1'(gi));
            assign w_dout[gi] = w_push[gi] ? w_src_data : '0;
        end
    endgenerate

    always_comb begin
        bus.vc0_pop   = w_grant[0];
        bus.vc1_pop   = w_grant[1];
        bus.d0_push   = w_push[0];
        bus.d1_push   = w_push[1];
        bus.d0_data   = w_dout[0];
        bus.d1_data   = w_dout[1];
        bus.active_vc = 2'b00;
        if ((r_state == XFER) && !reset) begin
            bus.active_vc = r_vc ? 2'b10 : 2'b01;
        end
        bus.vc0_count = r_vc0_count;
        bus.vc1_count = r_vc1_count;
    end

endmodule
